fetch_unit: RTL and testbench

//   Parametrised program counter plus instruction-fetch sequencer for the RISC core; supersedes the fixed 8-bit counter.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: controller requests, RAM read port and instruction/PC outputs.
interface fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int OFF_W   = 8
);
  logic               fetch_en;
  logic               branch_take;
  logic [OFF_W-1:0]   branch_off;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_valid;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               busy;
  logic [ADDR_W-1:0]  pc;

  modport slave (
    input  fetch_en, branch_take, branch_off, mem_rdata, mem_valid,
    output mem_req, mem_addr, instr, instr_valid, busy, pc
  );

  modport master (
    output fetch_en, branch_take, branch_off, mem_rdata, mem_valid,
    input  mem_req, mem_addr, instr, instr_valid, busy, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and instruction-fetch sequencer with PC-relative branches,
// including branches requested while a memory read is outstanding.
//   state  | meaning
//   S_IDLE | no fetch outstanding; branches apply to pc directly
//   S_WAIT | mem_req held at pc until mem_valid; branches are deferred
module fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter int              OFF_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam int EXT_W = ADDR_W - OFF_W;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               pend_br_q, pend_br_d;
  logic [OFF_W-1:0]   pend_off_q, pend_off_d;

  logic [ADDR_W-1:0]  br_ext;
  logic [ADDR_W-1:0]  pend_ext;
  logic [ADDR_W-1:0]  pc_inc;

  generate
    if (EXT_W == 0) begin : g_noext
      assign br_ext   = bus.branch_off;
      assign pend_ext = pend_off_q;
    end else begin : g_ext
      assign br_ext   = {{EXT_W{bus.branch_off[OFF_W-1]}}, bus.branch_off};
      assign pend_ext = {{EXT_W{pend_off_q[OFF_W-1]}}, pend_off_q};
    end
  endgenerate

  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pend_br_q     <= 1'b0;
      pend_off_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pend_br_q     <= pend_br_d;
      pend_off_q    <= pend_off_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    pend_br_d     = pend_br_q;
    pend_off_d    = pend_off_q;
    case (state_q)
      S_IDLE: begin
        // pc already points past the last fetched word, so the offset adds directly
        if (bus.branch_take) pc_d = pc_q + br_ext;
        if (bus.fetch_en)    state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_valid) begin
          instr_d       = bus.mem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_IDLE;
          pend_br_d     = 1'b0;
          if (bus.branch_take)  pc_d = pc_inc + br_ext;
          else if (pend_br_q)   pc_d = pc_inc + pend_ext;
          else                  pc_d = pc_inc;
        end else if (bus.branch_take) begin
          pend_br_d  = 1'b1;
          pend_off_d = bus.branch_off;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req     = (state_q == S_WAIT);
  assign bus.busy        = (state_q == S_WAIT);
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected instr/pc pairs queued at mem_valid,
// checked by a monitor on each instr_valid pulse.
module tb_fetch_unit;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int OFF_W   = 8;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W)) bus ();

  fetch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFF_W(OFF_W), .RESET_PC(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_valid", 32'(bus.instr_valid), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr_on_valid", 32'(bus.instr), 32'(e.instr));
        chk("pc_on_valid", 32'(bus.pc), 32'(e.pc));
      end
    end
  end

  task automatic start_fetch(input logic br, input logic [7:0] off);
    bus.fetch_en    = 1'b1;
    bus.branch_take = br;
    bus.branch_off  = off;
    @(negedge clk);
    bus.fetch_en    = 1'b0;
    bus.branch_take = 1'b0;
  endtask

  task automatic br_idle(input logic [7:0] off, input logic [7:0] exp_pc);
    bus.branch_take = 1'b1;
    bus.branch_off  = off;
    @(negedge clk);
    bus.branch_take = 1'b0;
    chk("pc_after_idle_branch", 32'(bus.pc), 32'(exp_pc));
    chk("idle_no_req", 32'(bus.mem_req), 32'h0);
  endtask

  // Called in WAIT; mem_valid is given on the last of lat request cycles.
  task automatic serve(input logic [15:0] data, input int lat, input logic poke,
                       input int pa, input logic [7:0] oa,
                       input int pb, input logic [7:0] ob,
                       input logic fb, input logic [7:0] fo,
                       input logic [7:0] addr, input logic [7:0] epc);
    for (int i = 0; i < lat; i++) begin
      chk("req_high", 32'(bus.mem_req), 32'h1);
      chk("busy_high", 32'(bus.busy), 32'h1);
      chk("addr_stable", 32'(bus.mem_addr), 32'(addr));
      bus.fetch_en    = poke && (i < lat - 1);
      bus.branch_take = 1'b0;
      if (i == pa) begin bus.branch_take = 1'b1; bus.branch_off = oa; end
      if (i == pb) begin bus.branch_take = 1'b1; bus.branch_off = ob; end
      if (i == lat - 1) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = data;
        if (fb) begin bus.branch_take = 1'b1; bus.branch_off = fo; end
        exp_q.push_back('{instr: data, pc: epc});
      end
      @(negedge clk);
      bus.mem_valid   = 1'b0;
      bus.fetch_en    = 1'b0;
      bus.branch_take = 1'b0;
    end
    chk("req_dropped", 32'(bus.mem_req), 32'h0);
    chk("pc_after_fetch", 32'(bus.pc), 32'(epc));
    @(negedge clk);
    chk("valid_one_cycle", 32'(bus.instr_valid), 32'h0);
    chk("still_idle", 32'(bus.mem_req), 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.fetch_en    = 1'b0;
    bus.branch_take = 1'b0;
    bus.branch_off  = '0;
    bus.mem_rdata   = '0;
    bus.mem_valid   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_pc", 32'(bus.pc), 32'h00);
    chk("rst_instr", 32'(bus.instr), 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // basic fetch, 1-cycle memory
    start_fetch(1'b0, 8'h00);
    serve(16'hA5C3, 1, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01);

    // 3-cycle memory with fetch_en noise during WAIT
    start_fetch(1'b0, 8'h00);
    serve(16'h1234, 3, 1'b1, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8'h01, 8'h02);

    // mem_valid in IDLE is ignored
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("idle_valid_instr", 32'(bus.instr), 32'h1234);
    chk("idle_valid_pc", 32'(bus.pc), 32'h02);
    @(negedge clk);

    // IDLE branch, then branch together with fetch_en
    br_idle(8'h0E, 8'h10);
    start_fetch(1'b1, 8'hFC);
    chk("br_fetch_pc", 32'(bus.pc), 32'h0C);
    serve(16'h0C0C, 1, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8'h0C, 8'h0D);

    // pending branch during WAIT, overwritten once
    br_idle(8'hF8, 8'h05);
    start_fetch(1'b0, 8'h00);
    serve(16'h5555, 4, 1'b0, 0, 8'h40, 1, 8'h03, 1'b0, 8'h00, 8'h05, 8'h09);

    // branch on the mem_valid cycle wins over the pending one
    br_idle(8'hFC, 8'h05);
    start_fetch(1'b0, 8'h00);
    serve(16'h7777, 4, 1'b0, 1, 8'h03, -1, 8'h00, 1'b1, 8'h01, 8'h05, 8'h07);

    // pending state cleared: plain increment follows
    start_fetch(1'b0, 8'h00);
    serve(16'h0707, 2, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8'h07, 8'h08);

    // wrap-around both directions
    br_idle(8'hF7, 8'hFF);
    start_fetch(1'b0, 8'h00);
    serve(16'hFFEE, 1, 1'b0, -1, 8'h00, -1, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00);
    br_idle(8'hFF, 8'hFF);

    // reset mid-WAIT, late mem_valid ignored
    start_fetch(1'b0, 8'h00);
    chk("pre_rst_req", 32'(bus.mem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("async_rst_req", 32'(bus.mem_req), 32'h0);
    chk("async_rst_busy", 32'(bus.busy), 32'h0);
    chk("async_rst_pc", 32'(bus.pc), 32'h00);
    chk("async_rst_instr", 32'(bus.instr), 32'h0);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("post_rst_instr", 32'(bus.instr), 32'h0);
    chk("post_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("post_rst_req", 32'(bus.mem_req), 32'h0);
    chk("post_rst_pc", 32'(bus.pc), 32'h00);
    @(negedge clk);
    chk("post_rst_valid2", 32'(bus.instr_valid), 32'h0);
    chk("final_scoreboard", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
